// File: rtl/sel_dec_pkg.sv
// Shared types and constants for the select decoder / sweep sequencer.
package sel_dec_pkg;

    localparam int DWELL_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/select_decoder_seq_if.sv
// Request/select bundle between a controller and select_decoder_seq.
interface select_decoder_seq_if #(
    parameter int N_OUT = 7,
    parameter int IDX_W = $clog2(N_OUT + 1)
);
    logic             mode;
    logic             idx_valid;
    logic [IDX_W-1:0] idx;
    logic             start;
    logic             hold;
    logic [N_OUT-1:0] sel_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output mode, idx_valid, idx, start, hold,
        input  sel_out, busy, done, err
    );

    modport slave (
        input  mode, idx_valid, idx, start, hold,
        output sel_out, busy, done, err
    );
endinterface

// File: rtl/onehot_dec.sv
// Combinational index decode: 0 or out-of-range -> all zeros, k -> bit k-1.
module onehot_dec #(
    parameter int N_OUT = 7,
    parameter int IDX_W = $clog2(N_OUT + 1)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N_OUT-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_OUT; i++) begin
            onehot[i] = (int'(idx) == i + 1);
        end
    end
endmodule

// File: rtl/select_decoder_seq.sv
// One-hot select driver with a direct decode path and a timed sweep.
// Build option: SEL_DEC_RANGE_CHECK_EN enables the out-of-range err pulse.
//
//   state | meaning
//   IDLE  | accepts direct decode (mode=0) or sweep start (mode=1)
//   SWEEP | walks one line per DWELL cycles, bit 0 upward; hold freezes
//   FIN   | one-cycle done pulse, all lines off, returns to IDLE
module select_decoder_seq
    import sel_dec_pkg::*;
#(
    parameter int N_OUT = 7,
    parameter int IDX_W = $clog2(N_OUT + 1),
    parameter int DWELL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    select_decoder_seq_if.slave bus
);
    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL - 1);
    localparam logic [N_OUT-1:0]       FIRST_LINE = {{(N_OUT-1){1'b0}}, 1'b1};

    state_t                 state_q, state_nxt;
    logic [N_OUT-1:0]       sel_q, sel_nxt;
    logic [DWELL_CNT_W-1:0] cnt_q, cnt_nxt;
    logic                   done_q, done_nxt;
    logic [N_OUT-1:0]       dec_sel;
    logic                   direct_req;

    onehot_dec #(
        .N_OUT (N_OUT),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx    (bus.idx),
        .onehot (dec_sel)
    );

    assign direct_req = (state_q == IDLE) && !bus.mode && bus.idx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            cnt_q   <= cnt_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mode && bus.start) begin
                    state_nxt = SWEEP;
                    sel_nxt   = FIRST_LINE;
                    cnt_nxt   = '0;
                end else if (direct_req) begin
                    sel_nxt = dec_sel;
                end
            end
            SWEEP: begin
                if (!bus.hold) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_nxt = '0;
                        // Last line expiring ends the sweep with every line off.
                        if (sel_q[N_OUT-1]) begin
                            state_nxt = FIN;
                            sel_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            sel_nxt = sel_q << 1;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef SEL_DEC_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= direct_req && (int'(bus.idx) > N_OUT);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.sel_out = sel_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_select_decoder_seq.sv
// Two configurations (N_OUT=7/DWELL=1 and N_OUT=6/DWELL=3) share one stimulus stream.
module tb_select_decoder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    select_decoder_seq_if #(.N_OUT(7)) ifa ();
    select_decoder_seq_if #(.N_OUT(6)) ifb ();

    select_decoder_seq #(.N_OUT(7), .DWELL(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    select_decoder_seq #(.N_OUT(6), .DWELL(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

`ifdef SEL_DEC_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef struct {
        logic [63:0] sel_a, sel_b;
        logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
    } exp_t;

    exp_t expq[$];

    // Reference model: a sweep is a position 0..N*DWELL, the last being the done cycle.
    int          nn[2] = '{7, 6};
    int          dw[2] = '{1, 3};
    logic        act[2];
    int          pos[2];
    logic [63:0] selm[2];
    logic        errm[2];

    task automatic model_edge(input int u, input logic rn, input logic m, input logic iv,
                              input logic [2:0] ix, input logic st, input logic hd);
        errm[u] = 1'b0;
        if (!rn) begin
            act[u]  = 1'b0;
            pos[u]  = 0;
            selm[u] = '0;
        end else if (act[u]) begin
            if (pos[u] == nn[u] * dw[u]) act[u] = 1'b0;
            else if (!hd) pos[u] = pos[u] + 1;
        end else if (m && st) begin
            act[u] = 1'b1;
            pos[u] = 0;
        end else if (!m && iv) begin
            selm[u] = (ix >= 1 && int'(ix) <= nn[u]) ? (64'd1 << (ix - 1)) : 64'd0;
            errm[u] = RANGE_CHK && (int'(ix) > nn[u]);
        end
        if (act[u]) selm[u] = (pos[u] < nn[u] * dw[u]) ? (64'd1 << (pos[u] / dw[u])) : 64'd0;
    endtask

    task automatic step(input logic rn, input logic m, input logic iv,
                        input logic [2:0] ix, input logic st, input logic hd);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        ifa.mode = m;  ifa.idx_valid = iv; ifa.idx = ix; ifa.start = st; ifa.hold = hd;
        ifb.mode = m;  ifb.idx_valid = iv; ifb.idx = ix; ifb.start = st; ifb.hold = hd;
        model_edge(0, rn, m, iv, ix, st, hd);
        model_edge(1, rn, m, iv, ix, st, hd);
        e.sel_a  = selm[0];
        e.sel_b  = selm[1];
        e.busy_a = act[0];
        e.busy_b = act[1];
        e.done_a = act[0] && (pos[0] == nn[0] * dw[0]);
        e.done_b = act[1] && (pos[1] == nn[1] * dw[1]);
        e.err_a  = errm[0];
        e.err_b  = errm[1];
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act_v, exp_v);
        end
    endtask

    // Monitor: every expectation describes the outputs right after one rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("a_sel",  64'(ifa.sel_out), e.sel_a);
            chk("a_busy", 64'(ifa.busy),    64'(e.busy_a));
            chk("a_done", 64'(ifa.done),    64'(e.done_a));
            chk("a_err",  64'(ifa.err),     64'(e.err_a));
            chk("b_sel",  64'(ifb.sel_out), e.sel_b);
            chk("b_busy", 64'(ifb.busy),    64'(e.busy_b));
            chk("b_done", 64'(ifb.done),    64'(e.done_b));
            chk("b_err",  64'(ifb.err),     64'(e.err_b));
            chk("a_onehot", 64'($countones(ifa.sel_out) <= 1), 64'd1);
            chk("b_onehot", 64'($countones(ifb.sel_out) <= 1), 64'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.mode = 0; ifa.idx_valid = 0; ifa.idx = 0; ifa.start = 0; ifa.hold = 0;
        ifb.mode = 0; ifb.idx_valid = 0; ifb.idx = 0; ifb.start = 0; ifb.hold = 0;

        // reset, with a start that must be discarded
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        // direct decode idx=3, then held
        step(1, 0, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // idx=0, then idx=7 (out of range on the N_OUT=6 instance)
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // idx_valid ignored in sweep mode, start ignored in direct mode
        step(1, 1, 1, 5, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        // full sweep with holds and stray requests while busy
        step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 26; i++) begin
            step(1, (i == 4) ? 1'b0 : 1'b1, (i == 4), 3'd5, (i == 3), (i == 7 || i == 8));
        end
        // reset mid-sweep while instance A shows bit 3, then restart
        step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 2, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 22; i++) step(1, 1, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        end
        step(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
